// File: rtl/bcd_seq_adder_pkg.sv
// Shared definitions for the BCD arithmetic blocks: FSM encodings, digit
// limit/correction constants and a digit validity helper.
package bcd_seq_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ADD   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_LIMIT = 4'd9;
    localparam logic [3:0] BCD_CORR  = 4'd6;

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > BCD_LIMIT;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: binary add of two BCD digits plus carry,
// then +6 correction whenever the binary sum leaves the decimal range.
module bcd_digit_add
    import bcd_seq_adder_pkg::*;
(
    input  logic [3:0] a_d,
    input  logic [3:0] b_d,
    input  logic       c,
    output logic [3:0] digit,
    output logic       carry
);

    logic [4:0] s;

    always_comb begin
        s     = {1'b0, a_d} + {1'b0, b_d} + {4'b0, c};
        digit = s[3:0];
        carry = 1'b0;
        if (s > {1'b0, BCD_LIMIT}) begin
            // 4-bit wrap of the low nibble gives (s + 6) mod 16
            digit = s[3:0] + BCD_CORR;
            carry = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_seq_adder.sv
// Sequential multi-digit BCD adder: validates captured operands, then adds
// one digit per cycle (LSD first) through a single shared digit adder.
module bcd_seq_adder
    import bcd_seq_adder_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] a,
    input  logic [4*N_DIGITS-1:0] b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS - 1);

    state_t                state_q;
    logic [4*N_DIGITS-1:0] a_q;
    logic [4*N_DIGITS-1:0] b_q;
    logic [IW-1:0]         idx_q;
    logic                  carry_q;
    logic                  busy_q;
    logic                  done_q;
    logic [4*N_DIGITS-1:0] sum_q;
    logic                  cout_q;
    logic                  err_q;

    logic [N_DIGITS-1:0]   bad_vec;
    logic                  bad;
    logic [3:0]            digit_d;
    logic                  carry_d;

    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_check
            assign bad_vec[gi] = digit_invalid(a_q[4*gi +: 4]) |
                                 digit_invalid(b_q[4*gi +: 4]);
        end
    endgenerate

    assign bad = |bad_vec;

    bcd_digit_add u_digit_add (
        .a_d   (a_q[4*idx_q +: 4]),
        .b_d   (b_q[4*idx_q +: 4]),
        .c     (carry_q),
        .digit (digit_d),
        .carry (carry_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (bad) begin
                        err_q   <= 1'b1;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        err_q   <= 1'b0;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    sum_q[4*idx_q +: 4] <= digit_d;
                    carry_q             <= carry_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= carry_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: doc/bcd_seq_adder.md
BCD_SEQ_ADDER -- requirements
Module: bcd_seq_adder

Interface
REQ-001 Parameter: N_DIGITS, default 4, number of packed BCD digits per operand (range 1..8).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 a  input  4*N_DIGITS  packed BCD operand A; digit 0 in [3:0].
REQ-006 b  input  4*N_DIGITS  packed BCD operand B.
REQ-007 cin  input  1  decimal carry-in to digit 0.
REQ-008 busy  output  1  high from the cycle after start is accepted until done.
REQ-009 done  output  1  one-cycle pulse; sum/cout/err valid in that cycle.
REQ-010 sum  output  4*N_DIGITS  packed BCD result, held until next accepted start.
REQ-011 cout  output  1  decimal carry out of the top digit, held with sum.
REQ-012 err  output  1  operand contained a digit > 9, held with sum.

Function
REQ-013 The block SHALL share one single-digit BCD adder across all digits, processing one digit per cycle, LSD first.
REQ-014 FSM states SHALL be IDLE, CHECK, ADD, DONE.
REQ-015 IDLE: start=1 SHALL capture a, b, cin into internal registers, clear digit index to 0, and enter CHECK.
REQ-016 CHECK (1 cycle): any captured digit > 9 SHALL route to DONE with err=1, sum=0, cout=0; otherwise to ADD with err=0.
REQ-017 ADD: each cycle, digit[idx] of A, B and the running carry SHALL go through the digit adder; the corrected digit SHALL be written to sum[4*idx+:4] and the carry registered.
REQ-018 ADD SHALL go to DONE after digit N_DIGITS-1; cout SHALL equal the carry out of that digit.
REQ-019 Digit adder: binary sum s = a_d + b_d + c (0..19); if s > 9, digit = s+6 mod 16, carry = 1; else digit = s, carry = 0.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 Latency: start accepted at cycle T; valid operands give done at T+N_DIGITS+2; invalid operands give done at T+2.
REQ-022 busy SHALL be high exactly in CHECK and ADD.
REQ-023 start while not in IDLE SHALL be ignored; inputs changing during busy SHALL not affect the result.
REQ-024 start in the same cycle done is high SHALL be ignored; the next start is accepted the following cycle, in IDLE.
REQ-025 sum, cout, err SHALL change only in CHECK (err, and zeroing when invalid) and ADD (sum digits, cout); otherwise held.

Reset
REQ-026 rst=1 SHALL force IDLE, busy=0, done=0, sum=0, cout=0, err=0, index=0, carry=0, regardless of state.
REQ-027 rst asserted mid-operation SHALL abandon the operation without a done pulse; start in the reset cycle SHALL be ignored.

Structure
REQ-028 FSM state encodings and the BCD limit constant (9) and correction constant (6) SHALL live in a shared package/header used by BCD blocks.
REQ-029 The per-digit combinational adder SHALL be a separate sub-module, bcd_digit_add (inputs a_d, b_d, c; outputs digit, carry), instantiated once.
REQ-030 Operand registers, digit index counter, carry register and FSM SHALL reside in bcd_seq_adder; no combinational path from inputs to outputs.

Verification (N_DIGITS=4)
REQ-031 a=0x1234, b=0x5678, cin=0, start -> done at T+6, sum=0x6912, cout=0, err=0.
REQ-032 a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0; a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1.
REQ-033 a=0x12A4, b=0x0000, start -> done at T+2, err=1, sum=0, cout=0, busy high only in cycle T+1.
REQ-034 start pulsed again at T+3 with a=0x1111 during 0x1234+0x5678 -> ignored, result 0x6912; start pulsed in the done cycle -> ignored.
REQ-035 rst asserted at T+3 of an add -> next cycle IDLE, all outputs 0, no done; a fresh 0x0005+0x0005 then gives sum=0x0010, cout=0.
